// File: rtl/regfile_dumper.sv
// regfile_dumper: walks a register file from START_ADDR to END_ADDR and
// streams every 32-bit register as four little-endian bytes over a
// valid/ready byte interface. Each register is snapshotted into a shift
// register before its bytes go out, so later register-file writes do not
// corrupt bytes that are already in flight.
module regfile_dumper #(
    parameter logic [4:0] START_ADDR = 5'd0,
    parameter logic [4:0] END_ADDR   = 5'd31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [4:0]  rd_addr,
    input  logic [31:0] rd_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_r;
    logic [4:0]  addr_r;
    logic [1:0]  byte_cnt_r;
    logic [31:0] shreg_r;
    logic        tx_valid_r;
    logic        busy_r;
    logic        done_r;

    // A byte leaves the block on every cycle where both handshake sides agree.
    logic xfer_s;
    assign xfer_s = tx_valid_r & tx_ready;

    // All outputs come straight from registers; the low shreg byte is the payload.
    assign rd_addr  = addr_r;
    assign tx_data  = shreg_r[7:0];
    assign tx_valid = tx_valid_r;
    assign busy     = busy_r;
    assign done     = done_r;

    // Dump sequencer: state, address, byte counter, snapshot and output flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            addr_r     <= START_ADDR;
            byte_cnt_r <= 2'd0;
            shreg_r    <= 32'd0;
            tx_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r     <= 1'b0;
                    tx_valid_r <= 1'b0;
                    if (start) begin
                        state_r <= LATCH;
                        addr_r  <= START_ADDR;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end

                LATCH: begin
                    // rd_addr already equals addr_r, so rd_data is this register.
                    shreg_r    <= rd_data;
                    byte_cnt_r <= 2'd0;
                    state_r    <= SEND;
                    tx_valid_r <= 1'b1;
                    busy_r     <= 1'b1;
                    done_r     <= 1'b0;
                end

                SEND: begin
                    busy_r <= 1'b1;
                    if (xfer_s) begin
                        if (byte_cnt_r != 2'd3) begin
                            shreg_r    <= {8'd0, shreg_r[31:8]};
                            byte_cnt_r <= byte_cnt_r + 2'd1;
                            tx_valid_r <= 1'b1;
                            done_r     <= 1'b0;
                        end else if (addr_r != END_ADDR) begin
                            addr_r     <= addr_r + 5'd1;
                            state_r    <= LATCH;
                            tx_valid_r <= 1'b0;
                            done_r     <= 1'b0;
                        end else begin
                            // Last register: hold addr so END_ADDR=31 cannot wrap.
                            state_r    <= DONE;
                            tx_valid_r <= 1'b0;
                            done_r     <= 1'b1;
                        end
                    end else begin
                        // Backpressure: payload and counters hold still.
                        tx_valid_r <= 1'b1;
                        done_r     <= 1'b0;
                    end
                end

                DONE: begin
                    // start is ignored here; it is sampled again in IDLE.
                    state_r    <= IDLE;
                    done_r     <= 1'b0;
                    busy_r     <= 1'b0;
                    tx_valid_r <= 1'b0;
                end

                default: begin
                    state_r    <= IDLE;
                    addr_r     <= START_ADDR;
                    byte_cnt_r <= 2'd0;
                    shreg_r    <= 32'd0;
                    tx_valid_r <= 1'b0;
                    busy_r     <= 1'b0;
                    done_r     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dumper.sv
// Self-checking bench for regfile_dumper: a behavioural register file, a byte
// scoreboard filled when a pass is requested and drained by a monitor, and a
// linear sequence of directed scenarios.
module tb_regfile_dumper;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic        rst, start, tx_ready;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [7:0]  tx_data;
    logic        tx_valid, busy, done;

    // Narrow-window instance (registers 1..2)
    logic        start_s, tx_ready_s;
    logic [4:0]  rd_addr_s;
    logic [31:0] rd_data_s;
    logic [7:0]  tx_data_s;
    logic        tx_valid_s, busy_s, done_s;

    logic [31:0] regs [0:31];
    assign rd_data   = regs[rd_addr];
    assign rd_data_s = regs[rd_addr_s];

    regfile_dumper dut (
        .clk(clk), .rst(rst), .start(start), .rd_addr(rd_addr), .rd_data(rd_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .done(done)
    );

    regfile_dumper #(.START_ADDR(5'd1), .END_ADDR(5'd2)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .rd_addr(rd_addr_s), .rd_data(rd_data_s),
        .tx_data(tx_data_s), .tx_valid(tx_valid_s), .tx_ready(tx_ready_s),
        .busy(busy_s), .done(done_s)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard of bytes the default instance still owes
    logic [7:0] exp_q [$];

    task automatic push_pass();
        for (int r = 0; r < 32; r++) begin
            for (int b = 0; b < 4; b++) begin
                exp_q.push_back(regs[r][8*b +: 8]);
            end
        end
    endtask

    // Monitor: drains scoreboard on transfers, checks hold under backpressure and done width
    int         xfers    = 0;
    int         done_cnt = 0;
    logic       pv = 1'b0, pr = 1'b0, pd = 1'b0;
    logic [7:0] pdat = 8'd0;
    always @(negedge clk) begin
        if (rst) begin
            pv = 1'b0;
            pd = 1'b0;
        end else begin
            if (pv && !pr) begin
                chk("hold_valid", 32'(tx_valid), 32'd1);
                chk("hold_data", 32'(tx_data), 32'(pdat));
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    assert (exp_q.size() != 0) else begin
                        errors++;
                        $error("FAIL unexpected_byte: observed %0h expected none", tx_data);
                    end
                end else begin
                    chk("stream_byte", 32'(tx_data), 32'(exp_q.pop_front()));
                end
                xfers++;
            end
            if (done) begin
                done_cnt++;
                chk("done_one_cycle", 32'(pd), 32'd0);
            end
            pv   = tx_valid;
            pr   = tx_ready;
            pdat = tx_data;
            pd   = done;
        end
    end

    // Waits for done on the default instance; cyc counts edges waited
    task automatic run_until_done(input int limit, input bit rnd, output int cyc);
        cyc = 0;
        while (cyc < limit) begin
            @(posedge clk); #1;
            cyc++;
            if (done) break;
            if (rnd) tx_ready = 1'($urandom_range(0, 1));
        end
        chk("pass_done_reached", 32'(done), 32'd1);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    logic [7:0] got_s [$];
    logic [7:0] exp8 [0:7];
    int cyc, base, dc;

    initial begin
        exp8 = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h67, 8'h45, 8'h23, 8'h01};
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        rst = 1'b1; start = 1'b1; tx_ready = 1'b0; start_s = 1'b1; tx_ready_s = 1'b1;

        // Reset overrides start
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'h00);
        chk("rst_rd_addr", 32'(rd_addr), 32'd0);
        chk("rst_rd_addr_s", 32'(rd_addr_s), 32'd1);
        start = 1'b0; start_s = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Narrow window: registers 1 and 2
        regs[1] = 32'hDEADBEEF;
        regs[2] = 32'h01234567;
        @(posedge clk); #1;
        start_s = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            start_s = 1'b0;
            if (done_s) break;
            if (tx_valid_s) got_s.push_back(tx_data_s);
        end
        chk("small_done", 32'(done_s), 32'd1);
        chk("small_count", 32'(got_s.size()), 32'd8);
        for (int i = 0; i < 8 && i < got_s.size(); i++) chk("small_byte", 32'(got_s[i]), 32'(exp8[i]));
        @(posedge clk); #1;
        chk("small_busy_after", 32'(busy_s), 32'd0);
        chk("small_done_after", 32'(done_s), 32'd0);

        // Full pass, tx_ready high, xN = N
        for (int i = 0; i < 32; i++) regs[i] = 32'(i);
        tx_ready = 1'b1;
        push_pass();
        dc = done_cnt;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("latch_busy", 32'(busy), 32'd1);
        chk("latch_tx_valid", 32'(tx_valid), 32'd0);
        chk("latch_rd_addr", 32'(rd_addr), 32'd0);
        @(posedge clk); #1;
        chk("first_tx_valid", 32'(tx_valid), 32'd1);
        run_until_done(400, 1'b0, cyc);
        chk("done_latency", 32'(cyc + 2), 32'd161);
        chk("done_rd_addr", 32'(rd_addr), 32'd31);
        @(posedge clk); #1;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("queue_empty_full", 32'(exp_q.size()), 32'd0);
        chk("done_count_full", 32'(done_cnt - dc), 32'd1);

        // Random backpressure
        push_pass();
        pulse_start();
        run_until_done(2000, 1'b1, cyc);
        tx_ready = 1'b1;
        @(posedge clk); #1;
        chk("queue_empty_bp", 32'(exp_q.size()), 32'd0);

        // Register write after snapshot of register 5
        push_pass();
        base = xfers;
        pulse_start();
        for (int k = 0; k < 400; k++) begin
            if (xfers - base == 21 && tx_valid) break;
            @(posedge clk); #1;
        end
        chk("at_reg5_byte1", 32'(rd_addr), 32'd5);
        regs[5] = 32'hFFFFFFFF;
        run_until_done(400, 1'b0, cyc);
        @(posedge clk); #1;
        chk("queue_empty_snap", 32'(exp_q.size()), 32'd0);
        regs[5] = 32'd5;

        // Reset mid-pass at byte 2 of register 10
        push_pass();
        base = xfers;
        dc = done_cnt;
        pulse_start();
        for (int k = 0; k < 400; k++) begin
            if (xfers - base == 42 && tx_valid) break;
            @(posedge clk); #1;
        end
        chk("at_reg10_byte2", 32'(rd_addr), 32'd10);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        chk("midrst_tx_valid", 32'(tx_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_rd_addr", 32'(rd_addr), 32'd0);
        repeat (6) @(posedge clk);
        #1;
        chk("midrst_no_done", 32'(done_cnt - dc), 32'd0);
        push_pass();
        pulse_start();
        run_until_done(400, 1'b0, cyc);
        @(posedge clk); #1;
        chk("queue_empty_restart", 32'(exp_q.size()), 32'd0);

        // start pulses while busy are ignored
        push_pass();
        dc = done_cnt;
        pulse_start();
        repeat (20) @(posedge clk);
        #1;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        run_until_done(400, 1'b0, cyc);
        repeat (10) @(posedge clk);
        #1;
        chk("busy_start_done_count", 32'(done_cnt - dc), 32'd1);
        chk("busy_start_idle", 32'(busy), 32'd0);
        chk("queue_empty_busy_start", 32'(exp_q.size()), 32'd0);

        // start held through DONE begins the next pass from IDLE
        push_pass();
        push_pass();
        @(posedge clk); #1;
        start = 1'b1;
        run_until_done(400, 1'b0, cyc);
        @(posedge clk); #1;
        chk("held_idle_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk("held_relatch_busy", 32'(busy), 32'd1);
        start = 1'b0;
        run_until_done(400, 1'b0, cyc);
        @(posedge clk); #1;
        chk("queue_empty_held", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
